// File: rtl/solver_thread_scheduler_pkg.sv
// Shared types and helpers for the WalkSAT thread scheduler.
// Holds the scheduler state encoding and the thread-index width helper.
package kanazawa_pkg;

    typedef enum logic [2:0] {
        LOAD,
        READY,
        ISSUE,
        WAIT,
        DONE
    } sched_state_e;

    function automatic int thread_w(input int nt);
        return (nt > 1) ? $clog2(nt) : 1;
    endfunction

endpackage

// File: rtl/solver_thread_scheduler_if.sv
// Step/result handshake between the thread scheduler and the datapath.
// master: scheduler (issues steps); slave: datapath (returns results).
interface solver_thread_scheduler_if #(
    parameter int TW = 2,
    parameter int UW = 11
);
    logic          step_valid;
    logic          step_ready;
    logic [TW-1:0] step_thread;
    logic          result_valid;
    logic [UW-1:0] unsat_count;

    modport master (
        output step_valid,
        output step_thread,
        input  step_ready,
        input  result_valid,
        input  unsat_count
    );

    modport slave (
        input  step_valid,
        input  step_thread,
        output step_ready,
        output result_valid,
        output unsat_count
    );
endinterface

// File: rtl/solver_thread_scheduler_rr_next_thread.sv
// Combinational round-robin pick: first live thread after cur, wrapping.
// Ports: live mask, cur index in; nxt index and none-live flag out.
module rr_next_thread #(
    parameter int NT = 4,
    parameter int TW = 2
) (
    input  logic [NT-1:0] live,
    input  logic [TW-1:0] cur,
    output logic [TW-1:0] nxt,
    output logic          none
);
    logic [TW-1:0] idx;

    // Scan farthest to nearest so the nearest live thread wins;
    // i == NT lands on cur itself (sole survivor case).
    always_comb begin
        nxt  = cur;
        none = 1'b1;
        idx  = '0;
        for (int i = NT; i >= 1; i--) begin
            idx = TW'((int'(cur) + i) % NT);
            if (live[idx]) begin
                nxt  = idx;
                none = 1'b0;
            end
        end
    end
endmodule

// File: rtl/solver_thread_scheduler.sv
// Shares one WalkSAT datapath among NUM_THREADS threads: load, round-robin run, SAT/UNSAT.
// Ports: clk_i/rst_ni, load_end_i/start_i/abort_i, dp (step/result handshake), status outputs.
module solver_thread_scheduler
    import kanazawa_pkg::*;
#(
    parameter int          NUM_THREADS = 4,
    parameter logic [31:0] MAX_FLIPS   = 32'h00FF_FFFF,
    parameter int          FLIP_W      = 32,
    parameter int          UNSAT_CNT_W = 11
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              load_end_i,
    input  logic                              start_i,
    input  logic                              abort_i,
    output logic [thread_w(NUM_THREADS)-1:0]  load_thread_o,
    solver_thread_scheduler_if.master         dp,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              sat_o,
    output logic [thread_w(NUM_THREADS)-1:0]  sat_thread_o,
    output logic                              protocol_err_o
);
    localparam int TW = thread_w(NUM_THREADS);
    localparam logic [FLIP_W-1:0] MAX_F = FLIP_W'(MAX_FLIPS);

    sched_state_e             state_q, state_d;
    logic [TW-1:0]            load_q, load_d;
    logic [TW-1:0]            thr_q, thr_d;
    logic [FLIP_W-1:0]        flips_q [NUM_THREADS];
    logic [FLIP_W-1:0]        flips_d [NUM_THREADS];
    logic [NUM_THREADS-1:0]   live_q, live_d, live_upd;
    logic                     sat_q, sat_d;
    logic [TW-1:0]            sat_thr_q, sat_thr_d;
    logic                     perr_q;
    logic [FLIP_W-1:0]        flip_inc;
    logic [TW-1:0]            rr_nxt;
    logic                     rr_none;

    // Saturating increment; reaching the budget retires the thread.
    always_comb begin
        flip_inc = (flips_q[thr_q] == MAX_F) ? MAX_F
                                             : flips_q[thr_q] + FLIP_W'(1);
        live_upd = live_q;
        if (flip_inc == MAX_F) live_upd[thr_q] = 1'b0;
    end

    rr_next_thread #(
        .NT (NUM_THREADS),
        .TW (TW)
    ) u_rr (
        .live (live_upd),
        .cur  (thr_q),
        .nxt  (rr_nxt),
        .none (rr_none)
    );

    always_comb begin
        state_d   = state_q;
        load_d    = load_q;
        thr_d     = thr_q;
        flips_d   = flips_q;
        live_d    = live_q;
        sat_d     = sat_q;
        sat_thr_d = sat_thr_q;
        if (abort_i) begin
            state_d   = LOAD;
            load_d    = '0;
            thr_d     = '0;
            live_d    = '1;
            sat_d     = 1'b0;
            sat_thr_d = '0;
            for (int i = 0; i < NUM_THREADS; i++) flips_d[i] = '0;
        end else begin
            unique case (1'b1)
                (state_q == LOAD): begin
                    if (load_end_i) begin
                        if (load_q == TW'(NUM_THREADS - 1)) state_d = READY;
                        else load_d = load_q + TW'(1);
                    end
                end
                (state_q == READY), (state_q == DONE): begin
                    // Restart reuses loaded images; only run state is cleared.
                    if (start_i) begin
                        state_d   = ISSUE;
                        thr_d     = '0;
                        live_d    = '1;
                        sat_d     = 1'b0;
                        sat_thr_d = '0;
                        for (int i = 0; i < NUM_THREADS; i++) flips_d[i] = '0;
                    end
                end
                (state_q == ISSUE): begin
                    if (dp.step_ready) state_d = WAIT;
                end
                (state_q == WAIT): begin
                    if (dp.result_valid) begin
                        if (dp.unsat_count == '0) begin
                            state_d   = DONE;
                            sat_d     = 1'b1;
                            sat_thr_d = thr_q;
                        end else begin
                            flips_d[thr_q] = flip_inc;
                            live_d         = live_upd;
                            if (rr_none) begin
                                state_d = DONE;
                            end else begin
                                state_d = ISSUE;
                                thr_d   = rr_nxt;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= LOAD;
            load_q    <= '0;
            thr_q     <= '0;
            live_q    <= '1;
            sat_q     <= 1'b0;
            sat_thr_q <= '0;
            perr_q    <= 1'b0;
            for (int i = 0; i < NUM_THREADS; i++) flips_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            thr_q     <= thr_d;
            live_q    <= live_d;
            sat_q     <= sat_d;
            sat_thr_q <= sat_thr_d;
            flips_q   <= flips_d;
            if (dp.result_valid && state_q != WAIT) perr_q <= 1'b1;
        end
    end

    assign load_thread_o  = load_q;
    assign dp.step_valid  = (state_q == ISSUE);
    assign dp.step_thread = thr_q;
    assign busy_o         = (state_q == ISSUE) || (state_q == WAIT);
    assign done_o         = (state_q == DONE);
    assign sat_o          = sat_q;
    assign sat_thread_o   = sat_thr_q;
    assign protocol_err_o = perr_q;
endmodule
